n64_event_queue: RTL and testbench
==================================

Name: n64_event_queue

Overview:
- Downstream consumer of the N64 receiver's 32-bit report (data_out/data_valid).
- Diffs each new report against the last one and serialises button press/release and joystick-move events into a FIFO.
- The host-side reader drains the FIFO with a valid/ready handshake.
- Sits between the N64 receiver and the Raspberry Pi register/SPI interface, so the host sees edges instead of polling full state.

Parameters:
DEPTH, 16, FIFO depth in events (power of two, >=2)
DEADBAND, 4, minimum |delta| of an axis vs. last reported value to emit an axis event (1..127)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
data_out  in  32  receiver report: [31:24] A,B,Z,START,D-UP,D-DOWN,D-LEFT,D-RIGHT; [23:22] ignored; [21:16] L,R,C-UP,C-DOWN,C-LEFT,C-RIGHT; [15:8] X signed; [7:0] Y signed
data_valid  in  1  one-cycle strobe, report valid
ev_data  out  16  head event
ev_valid  out  1  FIFO non-empty
ev_ready  in  1  host consumes head when ev_valid && ev_ready
buttons  out  14  last accepted button state, index order below
busy  out  1  scan in progress
overrun  out  1  sticky: report arrived while busy
dropped  out  8  saturating count of events lost to full FIFO
clear  in  1  synchronous clear of overrun and dropped

Behaviour:
- Reset (reset=0, async): FSM IDLE, prev buttons=0, last X/Y=0, FIFO empty, ev_valid=0, ev_data=0, buttons=0, busy=0, overrun=0, dropped=0.
- Button index: 0..7 = data_out[31:24] (A=0 .. D-RIGHT=7); 8..13 = data_out[21:16] (L=8 .. C-RIGHT=13).
- Event format:
  - [15:14] type: 00 release, 01 press, 10 X, 11 Y.
  - Button events: [11:8] index; [13:12]=0; [7:0]=0.
  - Axis events: [7:0] new signed value; [13:8]=0.
- FSM:
  - IDLE: on data_valid, latch report → SCAN with i=0; busy=1 from the next cycle.
  - SCAN: one button per cycle, i=0..13 ascending. If new[i]!=prev[i], push a press event (new=1) or release event (new=0), then update prev[i]. After i=13 → AXIS_X.
  - AXIS_X: delta = new_X − last_X as 9-bit signed. If delta!=0 and |delta|>=DEADBAND, push an X event and set last_X=new_X. Otherwise last_X is unchanged, so slow drift accumulates until it crosses the deadband. → AXIS_Y.
  - AXIS_Y: same rule for Y → IDLE; busy=0 in IDLE.
- Latency:
  - data_valid at cycle T → button i evaluated at cycle T+1+i; X at T+15; Y at T+16; IDLE at T+17.
  - A pushed event appears on ev_valid/ev_data the cycle after its push.
- buttons output updates bit by bit as SCAN progresses; it is final when busy falls.
- data_valid while busy: report discarded, overrun=1, scan continues unaffected. data_valid in the same cycle as the AXIS_Y→IDLE transition is also discarded.
- FIFO:
  - First-word-fall-through; ev_data is stable while ev_valid && !ev_ready.
  - Push when full: event lost, dropped += 1 (saturates at 255). Same-cycle pop on a full FIFO frees the slot, so the push succeeds.
  - Push and pop on an empty FIFO: the pushed event becomes the head next cycle.
  - Pointers wrap modulo DEPTH; full/empty use an extra pointer bit.
- clear: clears overrun/dropped next cycle. Simultaneous clear and a new overrun/drop event: the event wins (overrun=1, dropped=1).
- First report after reset: diffed against all-zero state, so pressed buttons generate press events and axes with |value|>=DEADBAND generate axis events.
- Reset mid-scan: all state returns to reset values immediately; partial events are lost.

Decomposition:
- Package n64_pkg:
  - event type enum (EV_RELEASE, EV_PRESS, EV_AXIS_X, EV_AXIS_Y)
  - button index constants BTN_A..BTN_C_RIGHT
  - report bit-position constants
  - event field positions
  - FSM state enum (IDLE, SCAN, AXIS_X, AXIS_Y)
- One sub-module: n64_event_fifo. Parameterised DEPTH and WIDTH=16; push/full, pop/valid; async active-low reset.

Test Plan:
- Reset, then report 0x8000_0000 (A) → exactly one event 0x4000 (press, index 0), visible at T+2; busy high T+1..T+16; buttons=14'h0001.
- Then report 0x0000_0000 → one event 0x0000 (release A). Then report 0x0001_0000 (C-RIGHT) → 0x4D00.
- Report X=0x03, Y=0x00 with DEADBAND=4 → no event. Next report X=0x05 → event 0x8005. Next report Y=0xF0 (−16) → event 0xC0F0.
- Report 0xFF3F_7F80 with ev_ready=0, DEPTH=16 → 16 events queued (14 press, X 0x807F, Y 0xC080) in index order, dropped=0. Next report all-zero → 16 events lost, dropped=16. clear → dropped=0.
- Second data_valid 5 cycles after the first → overrun=1; only the first report's events appear.
- Assert reset at T+7 mid-scan → ev_valid=0, buttons=0, busy=0 immediately. The next report re-generates presses from the zero state.

Source files
------------

// File: rtl/n64_pkg.sv
`default_nettype none
// ============================================================================
// Module : n64_pkg
// Brief  : Shared types and constants for the N64 event queue. Covers the
//          event encoding, the button index map, the receiver report bit
//          positions and the scanner FSM states.
// Rev    : 1.0  initial release
// ============================================================================
package n64_pkg;

    // Event type field, stored in bits [15:14] of every event
    typedef enum logic [1:0] {
        EV_RELEASE = 2'b00,
        EV_PRESS   = 2'b01,
        EV_AXIS_X  = 2'b10,
        EV_AXIS_Y  = 2'b11
    } ev_type_e;

    // Scanner states, with an explicit encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        AXIS_X = 2'd2,
        AXIS_Y = 2'd3
    } state_e;

    localparam int NUM_BUTTONS = 14;

    // Button indices, which are also the scan order
    localparam logic [3:0] BTN_A       = 4'd0;
    localparam logic [3:0] BTN_B       = 4'd1;
    localparam logic [3:0] BTN_Z       = 4'd2;
    localparam logic [3:0] BTN_START   = 4'd3;
    localparam logic [3:0] BTN_D_UP    = 4'd4;
    localparam logic [3:0] BTN_D_DOWN  = 4'd5;
    localparam logic [3:0] BTN_D_LEFT  = 4'd6;
    localparam logic [3:0] BTN_D_RIGHT = 4'd7;
    localparam logic [3:0] BTN_L       = 4'd8;
    localparam logic [3:0] BTN_R       = 4'd9;
    localparam logic [3:0] BTN_C_UP    = 4'd10;
    localparam logic [3:0] BTN_C_DOWN  = 4'd11;
    localparam logic [3:0] BTN_C_LEFT  = 4'd12;
    localparam logic [3:0] BTN_C_RIGHT = 4'd13;
    localparam logic [3:0] LAST_BTN    = BTN_C_RIGHT;

    // Receiver report layout
    localparam int RPT_BTN_HI_MSB = 31;  // A .. D-RIGHT, bits 31:24
    localparam int RPT_BTN_HI_LSB = 24;
    localparam int RPT_BTN_LO_MSB = 21;  // L .. C-RIGHT, bits 21:16
    localparam int RPT_BTN_LO_LSB = 16;
    localparam int RPT_X_MSB      = 15;
    localparam int RPT_X_LSB      = 8;
    localparam int RPT_Y_MSB      = 7;
    localparam int RPT_Y_LSB      = 0;

    // Event field positions
    localparam int EV_TYPE_LSB  = 14;
    localparam int EV_INDEX_LSB = 8;
    localparam int EV_VALUE_LSB = 0;

    // Map the two report button bytes onto button index order
    // (the MSB of each group is the lowest index)
    function automatic logic [NUM_BUTTONS-1:0] report_buttons(
        input logic [7:0] hi,
        input logic [5:0] lo
    );
        logic [NUM_BUTTONS-1:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) b[i]     = hi[7-i];
        for (int i = 0; i < 6; i++) b[8 + i] = lo[5-i];
        return b;
    endfunction

    function automatic logic [15:0] make_button_event(
        input logic       pressed,
        input logic [3:0] index
    );
        logic [15:0] ev;
        ev = '0;
        ev[EV_TYPE_LSB +: 2]  = pressed ? EV_PRESS : EV_RELEASE;
        ev[EV_INDEX_LSB +: 4] = index;
        return ev;
    endfunction

    function automatic logic [15:0] make_axis_event(
        input ev_type_e   kind,
        input logic [7:0] value
    );
        logic [15:0] ev;
        ev = '0;
        ev[EV_TYPE_LSB +: 2]  = kind;
        ev[EV_VALUE_LSB +: 8] = value;
        return ev;
    endfunction

endpackage
`default_nettype wire

// File: rtl/n64_event_fifo.sv
`default_nettype none
// ============================================================================
// Module : n64_event_fifo
// Brief  : First-word-fall-through FIFO for controller events. A pop on a
//          full FIFO frees the slot for a push in the same cycle. Full and
//          empty are told apart by an extra pointer wrap bit.
// Rev    : 1.0  initial release
// ============================================================================
module n64_event_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] pop_data
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             empty;
    logic             do_pop;
    logic             do_push;

    // Status flags and accepted transfers; the head reads as zero when empty
    always_comb begin
        empty    = (wr_ptr == rd_ptr);
        full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        valid    = !empty;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
    end

    // Pointer advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/n64_event_queue.sv
`default_nettype none
// ============================================================================
// Module : n64_event_queue
// Brief  : Compares each N64 receiver report with the previous state and
//          queues button press/release and joystick-move events for the
//          host. One button is scanned per cycle, then X, then Y.
// Rev    : 1.0  initial release
// ============================================================================
module n64_event_queue
    import n64_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int DEADBAND = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_out,
    input  logic        data_valid,
    output logic [15:0] ev_data,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [13:0] buttons,
    output logic        busy,
    output logic        overrun,
    output logic [7:0]  dropped,
    input  logic        clear
);
    localparam logic [8:0] DB = 9'(DEADBAND);

    state_e      state;
    logic [3:0]  idx;
    logic [13:0] new_btn;
    logic [7:0]  new_x;
    logic [7:0]  new_y;
    logic [7:0]  last_x;
    logic [7:0]  last_y;

    logic        push;
    logic [15:0] push_data;
    logic        fifo_full;
    logic [7:0]  ax_new;
    logic [7:0]  ax_last;
    logic [8:0]  delta;
    logic [8:0]  mag;
    logic        ax_hit;
    logic        overrun_evt;
    logic        drop_evt;

    // Report bits 23:22 carry nothing this block uses
    logic unused_report_bits;
    assign unused_report_bits = ^data_out[23:22];

    assign busy = (state != IDLE);

    // Event generation for the current scan step, including the axis deadband test
    always_comb begin
        ax_new    = (state == AXIS_Y) ? new_y : new_x;
        ax_last   = (state == AXIS_Y) ? last_y : last_x;
        delta     = {ax_new[7], ax_new} - {ax_last[7], ax_last};
        mag       = delta[8] ? (~delta + 9'd1) : delta;
        ax_hit    = (delta != 9'd0) && (mag >= DB);
        push      = 1'b0;
        push_data = '0;
        case (state)
            SCAN: begin
                if (new_btn[idx] != buttons[idx]) begin
                    push      = 1'b1;
                    push_data = make_button_event(new_btn[idx], idx);
                end
            end
            AXIS_X: begin
                push      = ax_hit;
                push_data = make_axis_event(EV_AXIS_X, new_x);
            end
            AXIS_Y: begin
                push      = ax_hit;
                push_data = make_axis_event(EV_AXIS_Y, new_y);
            end
            default: begin
                push      = 1'b0;
                push_data = '0;
            end
        endcase
        overrun_evt = data_valid && (state != IDLE);
        drop_evt    = push && fifo_full && !ev_ready;
    end

    // Scanner FSM: latch a report, walk the buttons, then each axis
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            idx     <= '0;
            new_btn <= '0;
            new_x   <= '0;
            new_y   <= '0;
            last_x  <= '0;
            last_y  <= '0;
            buttons <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_valid) begin
                        new_btn <= report_buttons(data_out[RPT_BTN_HI_MSB:RPT_BTN_HI_LSB],
                                                  data_out[RPT_BTN_LO_MSB:RPT_BTN_LO_LSB]);
                        new_x   <= data_out[RPT_X_MSB:RPT_X_LSB];
                        new_y   <= data_out[RPT_Y_MSB:RPT_Y_LSB];
                        idx     <= BTN_A;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    buttons[idx] <= new_btn[idx];
                    if (idx == LAST_BTN) state <= AXIS_X;
                    else                 idx   <= idx + 4'd1;
                end
                AXIS_X: begin
                    // Only a reported move updates the reference, so slow drift accumulates
                    if (ax_hit) last_x <= new_x;
                    state <= AXIS_Y;
                end
                AXIS_Y: begin
                    if (ax_hit) last_y <= new_y;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky overrun flag and saturating drop counter; a new event beats clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
            dropped <= '0;
        end else begin
            if (overrun_evt) overrun <= 1'b1;
            else if (clear)  overrun <= 1'b0;

            if (drop_evt) begin
                if (clear)                dropped <= 8'd1;
                else if (dropped != 8'hFF) dropped <= dropped + 8'd1;
            end else if (clear) begin
                dropped <= '0;
            end
        end
    end

    n64_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .full      (fifo_full),
        .pop       (ev_ready),
        .valid     (ev_valid),
        .pop_data  (ev_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_n64_event_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_n64_event_queue
// Brief  : Self-checking bench for n64_event_queue: vector table, hand-built
//          timing/overflow/overrun/reset sequences, and random reports
//          checked against a behavioural event model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_n64_event_queue;
    localparam int DEPTH    = 16;
    localparam int DEADBAND = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_out;
    logic        data_valid;
    logic [15:0] ev_data;
    logic        ev_valid;
    logic        ev_ready;
    logic [13:0] buttons;
    logic        busy;
    logic        overrun;
    logic [7:0]  dropped;
    logic        clear;

    always #5 clk = ~clk;

    n64_event_queue #(
        .DEPTH    (DEPTH),
        .DEADBAND (DEADBAND)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_out   (data_out),
        .data_valid (data_valid),
        .ev_data    (ev_data),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .buttons    (buttons),
        .busy       (busy),
        .overrun    (overrun),
        .dropped    (dropped),
        .clear      (clear)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];

    // Reference model state: button levels and last reported axis values
    bit m_btn[14];
    int m_lx;
    int m_ly;

    typedef struct {
        logic [31:0] rpt;
        int          n;
        logic [15:0] ev;
        logic [13:0] btn;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 14; i++) m_btn[i] = 1'b0;
        m_lx = 0;
        m_ly = 0;
    endtask

    // Events a report should produce, from the button/axis rules directly
    task automatic model_report(input logic [31:0] r);
        bit         b;
        logic [7:0] xb;
        logic [7:0] yb;
        int         nx;
        int         ny;
        int         d;
        for (int i = 0; i < 14; i++) begin
            b = (i < 8) ? r[31 - i] : r[21 - (i - 8)];
            if (b != m_btn[i]) begin
                exp_q.push_back({(b ? 2'b01 : 2'b00), 2'b00, 4'(i), 8'h00});
                m_btn[i] = b;
            end
        end
        xb = r[15:8];
        yb = r[7:0];
        nx = $signed(xb);
        ny = $signed(yb);
        d = nx - m_lx;
        if (d < 0) d = -d;
        if (d != 0 && d >= DEADBAND) begin
            exp_q.push_back({2'b10, 6'b0, xb});
            m_lx = nx;
        end
        d = ny - m_ly;
        if (d < 0) d = -d;
        if (d != 0 && d >= DEADBAND) begin
            exp_q.push_back({2'b11, 6'b0, yb});
            m_ly = ny;
        end
    endtask

    function automatic logic [13:0] model_buttons();
        logic [13:0] v;
        for (int i = 0; i < 14; i++) v[i] = m_btn[i];
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        ev_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        model_reset();
    endtask

    task automatic wait_idle(input string nm);
        int g = 0;
        while (busy && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk({nm, "_scan_done"}, 32'(busy), 32'd0);
    endtask

    task automatic apply_report(input logic [31:0] r, input string nm);
        @(negedge clk);
        data_out   = r;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        wait_idle(nm);
    endtask

    // Pop everything expected, optionally with a random ready pattern
    task automatic drain(input string nm, input bit rnd);
        int g = 0;
        while (exp_q.size() > 0 && g < 500) begin
            @(negedge clk);
            g++;
            ev_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ev_valid && ev_ready) begin
                chk(nm, 32'(ev_data), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
        chk({nm, "_missing"}, exp_q.size(), 32'd0);
        exp_q.delete();
        @(negedge clk);
        ev_ready = 1'b0;
        chk({nm, "_extra"}, 32'(ev_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] prev;

        tbl[0] = '{32'h0000_0000, 1, 16'h0000, 14'h0000};
        tbl[1] = '{32'h0001_0000, 1, 16'h4D00, 14'h2000};
        tbl[2] = '{32'h0001_0300, 0, 16'h0000, 14'h2000};
        tbl[3] = '{32'h0001_0500, 1, 16'h8005, 14'h2000};
        tbl[4] = '{32'h0001_05F0, 1, 16'hC0F0, 14'h2000};
        tbl[5] = '{32'h0000_05F0, 1, 16'h0D00, 14'h0000};
        tbl[6] = '{32'h0000_01F3, 1, 16'h8001, 14'h0000};
        tbl[7] = '{32'h0000_01EF, 0, 16'h0000, 14'h0000};
        tbl[8] = '{32'h0000_01EC, 1, 16'hC0EC, 14'h0000};

        reset      = 1'b0;
        data_out   = '0;
        data_valid = 1'b0;
        ev_ready   = 1'b0;
        clear      = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ev_valid", 32'(ev_valid), 32'd0);
        chk("rst_ev_data", 32'(ev_data), 32'd0);
        chk("rst_buttons", 32'(buttons), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_dropped", 32'(dropped), 32'd0);
        reset = 1'b1;

        // First report: press A, with exact latency
        @(negedge clk);
        data_out   = 32'h8000_0000;
        data_valid = 1'b1;
        @(negedge clk);                 // T+1
        data_valid = 1'b0;
        chk("lat_busy_t1", 32'(busy), 32'd1);
        chk("lat_valid_t1", 32'(ev_valid), 32'd0);
        @(negedge clk);                 // T+2
        chk("lat_valid_t2", 32'(ev_valid), 32'd1);
        chk("lat_data_t2", 32'(ev_data), 32'h4000);
        repeat (14) @(negedge clk);     // T+16
        chk("lat_busy_t16", 32'(busy), 32'd1);
        @(negedge clk);                 // T+17
        chk("lat_busy_t17", 32'(busy), 32'd0);
        chk("lat_buttons", 32'(buttons), 32'h0001);
        exp_q.push_back(16'h4000);
        drain("lat_ev", 1'b0);

        // Vector table: buttons, deadband both sides, drift accumulation
        for (int k = 0; k < 9; k++) begin
            apply_report(tbl[k].rpt, $sformatf("row%0d", k));
            chk($sformatf("row%0d_buttons", k), 32'(buttons), 32'(tbl[k].btn));
            chk($sformatf("row%0d_dropped", k), 32'(dropped), 32'd0);
            if (tbl[k].n == 1) exp_q.push_back(tbl[k].ev);
            drain($sformatf("row%0d_ev", k), 1'b0);
        end

        // Fill to full, then a push coinciding with a pop, then overflow
        do_reset();
        apply_report(32'hFF3F_7F80, "full");
        chk("full_dropped", 32'(dropped), 32'd0);
        chk("full_buttons", 32'(buttons), 32'h3FFF);
        @(negedge clk);
        data_out   = 32'h7F3F_7F80;
        data_valid = 1'b1;
        @(negedge clk);                 // T+1: release A pushed while head pops
        data_valid = 1'b0;
        ev_ready   = 1'b1;
        chk("fullpop_head", 32'(ev_data), 32'h4000);
        @(negedge clk);
        ev_ready = 1'b0;
        wait_idle("fullpop");
        chk("fullpop_dropped", 32'(dropped), 32'd0);
        apply_report(32'h0000_0000, "ovf");
        chk("ovf_dropped", 32'(dropped), 32'd15);
        chk("ovf_buttons", 32'(buttons), 32'd0);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_dropped", 32'(dropped), 32'd0);
        for (int i = 1; i < 14; i++) exp_q.push_back(16'h4000 | 16'(i << 8));
        exp_q.push_back(16'h807F);
        exp_q.push_back(16'hC080);
        exp_q.push_back(16'h0000);
        drain("full_ev", 1'b1);

        // Second report 5 cycles into a scan is discarded
        @(negedge clk);
        data_out   = 32'h4000_0000;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (4) @(negedge clk);      // T+5
        data_out   = 32'h2000_0000;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        wait_idle("ovr");
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_buttons", 32'(buttons), 32'h0002);
        exp_q.push_back(16'h4100);
        drain("ovr_ev", 1'b0);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("ovr_clear", 32'(overrun), 32'd0);

        // Report on the last scan cycle, together with clear: overrun wins
        @(negedge clk);
        data_out   = 32'h0000_0000;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (15) @(negedge clk);     // T+16
        data_out   = 32'hFFFF_FFFF;
        data_valid = 1'b1;
        clear      = 1'b1;
        @(negedge clk);                 // T+17
        data_valid = 1'b0;
        clear      = 1'b0;
        chk("edge_busy", 32'(busy), 32'd0);
        chk("edge_overrun", 32'(overrun), 32'd1);
        @(negedge clk);
        chk("edge_busy2", 32'(busy), 32'd0);
        chk("edge_buttons", 32'(buttons), 32'd0);
        exp_q.push_back(16'h0100);
        drain("edge_ev", 1'b0);

        // Reset in the middle of a scan
        @(negedge clk);
        data_out   = 32'hC000_0000;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (6) @(negedge clk);      // T+7
        chk("mid_buttons_pre", 32'(buttons), 32'h0003);
        chk("mid_valid_pre", 32'(ev_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_valid", 32'(ev_valid), 32'd0);
        chk("mid_buttons", 32'(buttons), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        apply_report(32'hC000_0000, "mid_again");
        chk("mid_again_buttons", 32'(buttons), 32'h0003);
        exp_q.push_back(16'h4000);
        exp_q.push_back(16'h4100);
        drain("mid_again_ev", 1'b0);

        // Random reports against the behavioural model
        do_reset();
        prev = '0;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 2))
                0: r = $urandom;
                1: r = prev ^ (32'h1 << $urandom_range(0, 31));
                default: begin
                    r = prev;
                    r[15:8] = r[15:8] + 8'($urandom_range(0, 12)) - 8'd6;
                    r[7:0]  = r[7:0] + 8'($urandom_range(0, 12)) - 8'd6;
                end
            endcase
            prev = r;
            model_report(r);
            apply_report(r, "rnd");
            chk("rnd_buttons", 32'(buttons), 32'(model_buttons()));
            chk("rnd_dropped", 32'(dropped), 32'd0);
            chk("rnd_overrun", 32'(overrun), 32'd0);
            drain("rnd_ev", 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
